// File: rtl/lab1_imul_int_div_iter.sv
// Iterative restoring divider: {a, b} in, {remainder, quotient} out, one quotient bit per cycle.
// Latency: N+1 cycles from accept to ostream_val (1 cycle when b==0); throughput one op per N+2 cycles.
// Backpressure: result held stable in DONE until ostream_rdy; no new request accepted until then.
// Optional feature macro: LAB1_IMUL_DIV_SIGNED_EN (two's-complement signed division).

module lab1_imul_int_div_iter #(
  parameter int p_nbits = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   istream_val,
  output logic                   istream_rdy,
  input  logic [2*p_nbits-1:0]   istream_msg,
  output logic                   ostream_val,
  input  logic                   ostream_rdy,
  output logic [2*p_nbits-1:0]   ostream_msg
);

  localparam int CW = $clog2(p_nbits + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [p_nbits-1:0] quot_q;
  logic [p_nbits-1:0] rem_q;
  logic [p_nbits-1:0] dvsr_q;
  logic [CW-1:0]      cnt_q;

  logic [p_nbits-1:0] a_in;
  logic [p_nbits-1:0] b_in;
  logic [p_nbits-1:0] a_mag;
  logic [p_nbits-1:0] b_mag;
  logic               b_zero;
  logic               last_step;

  // Trial subtraction: shifted remainder is at most 2B-1, so N+1 bits plus a sign bit.
  logic [p_nbits+1:0] diff;
  logic               diff_neg;
  logic [p_nbits-1:0] rem_shift;

  logic [p_nbits-1:0] quot_out;
  logic [p_nbits-1:0] rem_out;

  assign a_in   = istream_msg[2*p_nbits-1:p_nbits];
  assign b_in   = istream_msg[p_nbits-1:0];
  assign b_zero = (b_in == '0);

`ifdef LAB1_IMUL_DIV_SIGNED_EN
  logic sign_a_q;
  logic sign_b_q;
  logic div0_q;

  // Core always works on magnitudes; most-negative maps onto itself, which is the right unsigned magnitude.
  assign a_mag = a_in[p_nbits-1] ? (~a_in + 1'b1) : a_in;
  assign b_mag = b_in[p_nbits-1] ? (~b_in + 1'b1) : b_in;

  // Latch operand signs on accept; divide-by-zero must bypass quotient negation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      div0_q   <= 1'b0;
    end else if (state == IDLE && istream_val) begin
      sign_a_q <= a_in[p_nbits-1];
      sign_b_q <= b_in[p_nbits-1];
      div0_q   <= b_zero;
    end
  end

  // Sign fixup on the way out: truncation toward zero, remainder follows the dividend.
  always_comb begin
    quot_out = quot_q;
    rem_out  = rem_q;
    if ((sign_a_q ^ sign_b_q) && !div0_q) quot_out = ~quot_q + 1'b1;
    if (sign_a_q)                         rem_out  = ~rem_q + 1'b1;
  end
`else
  assign a_mag = a_in;
  assign b_mag = b_in;

  // Unsigned results leave the registers untouched.
  always_comb begin
    quot_out = quot_q;
    rem_out  = rem_q;
  end
`endif

  assign diff      = {1'b0, rem_q, quot_q[p_nbits-1]} - {2'b00, dvsr_q};
  assign diff_neg  = diff[p_nbits+1];
  assign rem_shift = {rem_q[p_nbits-2:0], quot_q[p_nbits-1]};
  assign last_step = (cnt_q == CW'(1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: divide-by-zero skips CALC entirely; unknown encodings recover to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (istream_val) state_nxt = b_zero ? DONE : CALC;
      CALC:    if (last_step)   state_nxt = DONE;
      DONE:    if (ostream_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load operands on accept, one shift/subtract step per CALC cycle, hold in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (istream_val) begin
            dvsr_q <= b_mag;
            cnt_q  <= CW'(p_nbits);
            if (b_zero) begin
              quot_q <= '1;
              rem_q  <= a_mag;
            end else begin
              quot_q <= a_mag;
              rem_q  <= '0;
            end
          end
        end
        CALC: begin
          rem_q  <= diff_neg ? rem_shift : diff[p_nbits-1:0];
          quot_q <= {quot_q[p_nbits-2:0], ~diff_neg};
          cnt_q  <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign istream_rdy = (state == IDLE) && !reset;
  assign ostream_val = (state == DONE);
  assign ostream_msg = {rem_out, quot_out};

endmodule

// File: tb/tb_lab1_imul_int_div_iter.sv
// Scoreboard bench for lab1_imul_int_div_iter: driver pushes expected {rem, quot} and latency,
// a negedge monitor compares every response cycle, random source gaps and sink stalls.
// Build with LAB1_IMUL_DIV_SIGNED_EN to exercise the signed variant.

module tb_lab1_imul_int_div_iter;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          istream_val;
  logic          istream_rdy;
  logic [2*N-1:0] istream_msg;
  logic          ostream_val;
  logic          ostream_rdy;
  logic [2*N-1:0] ostream_msg;

  lab1_imul_int_div_iter #(.p_nbits(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .istream_msg (istream_msg),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [2*N-1:0] exp_msg_q[$];
  int             exp_lat_q[$];
  int             acc_cyc_q[$];

  bit sink_hold = 1'b0;
  int sink_pct  = 100;
  bit val_prev  = 1'b0;
  bit chk_idle  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the operand values.
  function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] q, r;
`ifdef LAB1_IMUL_DIV_SIGNED_EN
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 0) begin
      q = '1; r = a;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = '0;
    end else begin
      q = N'(sa / sb); r = N'(sa % sb);
    end
`else
    if (b == 0) begin
      q = '1; r = a;
    end else begin
      q = a / b; r = a % b;
    end
`endif
    return {r, q};
  endfunction

  // Sink: random or forced-low ready, changed just after each edge.
  always @(posedge clk) begin
    #1;
    ostream_rdy = sink_hold ? 1'b0 : ($urandom_range(1, 100) <= sink_pct);
  end

  // Monitor: checks latency at the rising edge of val, message/busy every DONE cycle, idle after handshake.
  always @(negedge clk) begin
    if (reset) begin
      val_prev = 1'b0;
      chk_idle = 1'b0;
    end else begin
      if (chk_idle) begin
        check("idle_rdy_after_handshake", {63'd0, istream_rdy}, 64'd1);
        chk_idle = 1'b0;
      end
      if (ostream_val) begin
        if (exp_msg_q.size() == 0) begin
          check("unexpected_response", ostream_msg, '0);
        end else begin
          if (!val_prev)
            check("latency", 64'(cyc - acc_cyc_q[0] + 1), 64'(exp_lat_q[0]));
          check("resp_msg", ostream_msg, exp_msg_q[0]);
          check("busy_rdy", {63'd0, istream_rdy}, 64'd0);
          if (ostream_rdy) begin
            void'(exp_msg_q.pop_front());
            void'(exp_lat_q.pop_front());
            void'(acc_cyc_q.pop_front());
            chk_idle = 1'b1;
          end
        end
      end
      val_prev = ostream_val;
    end
  end

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    int guard;
    guard = 0;
    @(posedge clk);
    #1;
    istream_val = 1'b1;
    istream_msg = {a, b};
    forever begin
      @(negedge clk);
      if (istream_rdy) break;
      guard++;
      if (guard > 400) begin
        check("accept_timeout", 64'd0, 64'd1);
        istream_val = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    exp_msg_q.push_back(model(a, b));
    exp_lat_q.push_back((b == 0) ? 1 : N + 1);
    acc_cyc_q.push_back(cyc);
    istream_val = 1'b0;
    istream_msg = {$urandom, $urandom};
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_msg_q.size() != 0 && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    if (exp_msg_q.size() != 0) check("drain_timeout", 64'(exp_msg_q.size()), 64'd0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] ra, rb;
    int           guard;

    reset       = 1'b1;
    istream_val = 1'b0;
    istream_msg = '0;
    ostream_rdy = 1'b0;

    #3;
    check("reset_istream_rdy", {63'd0, istream_rdy}, 64'd0);
    check("reset_ostream_val", {63'd0, ostream_val}, 64'd0);
    check("reset_ostream_msg", ostream_msg, 64'd0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Directed values with an always-ready sink.
    sink_pct = 100;
    issue(32'd100, 32'd7);          drain();
    issue(32'd5, 32'd0);            drain();
    issue(32'hFFFF_FFFF, 32'd1);    drain();
    issue(32'd3, 32'hFFFF_FFFF);    drain();
    issue(32'd0, 32'd9);            drain();
    issue(32'hDEAD_BEEF, 32'hDEAD_BEEF); drain();

    // Backpressure: hold DONE for 10 cycles, message must stay put.
    sink_hold = 1'b1;
    issue(32'd1000, 32'd10);
    guard = 0;
    while (!ostream_val && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    if (!ostream_val) check("hold_reach_done", 64'd0, 64'd1);
    repeat (10) @(posedge clk);
    sink_hold = 1'b0;
    drain();

    // Reset mid-CALC drops the transaction.
    issue(32'd1234, 32'd5);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_ostream_val", {63'd0, ostream_val}, 64'd0);
    check("midreset_istream_rdy", {63'd0, istream_rdy}, 64'd0);
    exp_msg_q.delete();
    exp_lat_q.delete();
    acc_cyc_q.delete();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    issue(32'd9, 32'd3);
    drain();

`ifdef LAB1_IMUL_DIV_SIGNED_EN
    issue(-32'sd7, 32'sd2);                 drain();
    issue(32'h8000_0000, 32'hFFFF_FFFF);    drain();
    issue(-32'sd100, -32'sd7);              drain();
    issue(32'sd100, -32'sd7);               drain();
    issue(-32'sd5, 32'sd0);                 drain();
`endif

    // Random operations with random source gaps and sink stalls.
    sink_pct = 60;
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = N'($urandom_range(0, 20));
        1:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) ra = N'($urandom_range(0, 3)) << 30;
      issue(ra, rb);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
